// File: rtl/exec_decode_unit.sv
// Execute/decode slice: operand select, ALU, one-hot write enable, RAM address mux, NZCV flag register.
// Define ALU_SHIFT_EN to build LSL/LSR; without it those opcodes decode as NOP.
module exec_decode_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch,
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic        seladdbusmux,
    input  logic [31:0] addbusaccess,
    input  logic [31:0] pcinstruct,
    output logic [31:0] result,
    output logic [15:0] en,
    output logic [31:0] addressbus,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v
);
    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                           OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_ORR = 4'h7,
                           OP_MOV = 4'h8, OP_LDR = 4'h9, OP_CMP = 4'hB,
                           OP_LSL = 4'hC, OP_LSR = 4'hD, OP_MVN = 4'hE;

    logic [3:0]  w_cond, w_op, w_rd;
    logic        w_s, w_cond_pass;
    logic [31:0] w_op_b, w_add_x, w_add_y, w_result;
    logic        w_add_cin, w_arith, w_s_able, w_writes, w_shift, w_shift_c, w_ovf, w_flag_upd;
    logic [32:0] w_sum;
    logic        r_n, r_z, r_c, r_v;
    logic        w_unused;

    assign w_cond = fetch[31:28];
    assign w_op   = fetch[27:24];
    assign w_s    = fetch[23];
    assign w_rd   = fetch[22:19];
    assign w_op_b = fetch[10] ? {22'd0, fetch[9:0]} : s2;
    // Rn/Rm select fields drive the register-bank muxes upstream, not this slice.
    assign w_unused = ^fetch[18:11];

    assign addressbus = seladdbusmux ? addbusaccess : pcinstruct;

    always_comb begin
        case (w_cond)
            4'h0: w_cond_pass = r_z;
            4'h1: w_cond_pass = !r_z;
            4'h2: w_cond_pass = r_c;
            4'h3: w_cond_pass = !r_c;
            4'h4: w_cond_pass = r_n;
            4'h5: w_cond_pass = !r_n;
            4'h6: w_cond_pass = r_v;
            4'h7: w_cond_pass = !r_v;
            4'h8: w_cond_pass = r_c && !r_z;
            4'h9: w_cond_pass = !r_c || r_z;
            4'hA: w_cond_pass = (r_n == r_v);
            4'hB: w_cond_pass = (r_n != r_v);
            4'hC: w_cond_pass = !r_z && (r_n == r_v);
            4'hD: w_cond_pass = r_z || (r_n != r_v);
            default: w_cond_pass = 1'b1;
        endcase
    end

    // All add/subtract forms share one adder: subtraction is x + ~y + carry-in.
    always_comb begin
        w_add_x   = s1;
        w_add_y   = w_op_b;
        w_add_cin = 1'b0;
        case (w_op)
            OP_SUB, OP_CMP: begin w_add_y = ~w_op_b; w_add_cin = 1'b1; end
            OP_RSB:         begin w_add_x = w_op_b; w_add_y = ~s1; w_add_cin = 1'b1; end
            OP_ADC:         w_add_cin = r_c;
            OP_SBC:         begin w_add_y = ~w_op_b; w_add_cin = r_c; end
            default:        ;
        endcase
    end

    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {32'd0, w_add_cin};
    assign w_ovf = (w_add_x[31] == w_add_y[31]) && (w_sum[31] != w_add_x[31]);

`ifdef ALU_SHIFT_EN
    logic [4:0] w_sh;
    assign w_sh = w_op_b[4:0];
`endif

    always_comb begin
        w_result  = 32'd0;
        w_arith   = 1'b0;
        w_s_able  = 1'b0;
        w_writes  = 1'b0;
        w_shift   = 1'b0;
        w_shift_c = r_c;
        case (w_op)
            OP_AND: begin w_result = s1 & w_op_b;  w_s_able = 1'b1; w_writes = 1'b1; end
            OP_EOR: begin w_result = s1 ^ w_op_b;  w_s_able = 1'b1; w_writes = 1'b1; end
            OP_ORR: begin w_result = s1 | w_op_b;  w_s_able = 1'b1; w_writes = 1'b1; end
            OP_MOV: begin w_result = w_op_b;       w_s_able = 1'b1; w_writes = 1'b1; end
            OP_MVN: begin w_result = ~w_op_b;      w_s_able = 1'b1; w_writes = 1'b1; end
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC: begin
                w_result = w_sum[31:0];
                w_arith  = 1'b1;
                w_s_able = 1'b1;
                w_writes = 1'b1;
            end
            OP_CMP: begin w_result = w_sum[31:0]; w_arith = 1'b1; end
            OP_LDR: w_writes = 1'b1;
`ifdef ALU_SHIFT_EN
            // Carry is the last bit pushed out; index 0 - sh wraps to 32 - sh.
            OP_LSL: begin
                w_result = s1 << w_sh;
                w_s_able = 1'b1;
                w_writes = 1'b1;
                w_shift  = 1'b1;
                if (w_sh != 5'd0) w_shift_c = s1[5'd0 - w_sh];
            end
            OP_LSR: begin
                w_result = s1 >> w_sh;
                w_s_able = 1'b1;
                w_writes = 1'b1;
                w_shift  = 1'b1;
                if (w_sh != 5'd0) w_shift_c = s1[w_sh - 5'd1];
            end
`endif
            default: ;
        endcase
    end

    assign result     = w_result;
    assign en         = (w_cond_pass && w_writes) ? (16'd1 << w_rd) : 16'd0;
    assign w_flag_upd = w_cond_pass && ((w_s && w_s_able) || (w_op == OP_CMP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_flag_upd) begin
            r_n <= w_result[31];
            r_z <= (w_result == 32'd0);
            if (w_arith) begin
                r_c <= w_sum[32];
                r_v <= w_ovf;
            end else if (w_shift) begin
                r_c <= w_shift_c;
            end
        end
    end

    assign n = r_n;
    assign z = r_z;
    assign c = r_c;
    assign v = r_v;
endmodule

// File: tb/tb_exec_decode_unit.sv
// Bench for exec_decode_unit: arithmetic reference model plus directed vectors with literal expectations.
module tb_exec_decode_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch = 32'd0, s1 = 32'd0, s2 = 32'd0;
    logic        sel = 1'b0;
    logic [31:0] abus = 32'd0, pc = 32'd0;
    logic [31:0] result, addressbus;
    logic [15:0] en;
    logic        n, z, c, v;

    exec_decode_unit dut (
        .clk(clk), .reset(reset), .fetch(fetch), .s1(s1), .s2(s2),
        .seladdbusmux(sel), .addbusaccess(abus), .pcinstruct(pc),
        .result(result), .en(en), .addressbus(addressbus),
        .n(n), .z(z), .c(c), .v(v)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    bit run = 1'b0;
    bit lc_res = 0, lc_en = 0, lc_addr = 0, lc_fl = 0;
    logic [31:0] l_res = 0, l_addr = 0;
    logic [15:0] l_en = 0;
    logic [3:0]  l_fl = 0;

    logic [3:0]  m_fl = 4'd0;
    logic [31:0] m_res;
    logic [15:0] m_en;
    bit          m_upd;
    logic [3:0]  m_nfl;

    localparam int AL = 14, EQ = 0;
    localparam int AND_ = 0, EOR = 1, SUB = 2, RSB = 3, ADD = 4, ADC = 5, SBC = 6, ORR = 7,
                   MOV = 8, LDR = 9, STR = 10, CMP = 11, LSL = 12, LSR = 13, MVN = 14, NOP = 15;

    function automatic bit ovf(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // Reference: 64-bit arithmetic, carry = unsigned range / no-borrow, overflow = signed range.
    function automatic void model(input logic [31:0] f, input logic [31:0] a, input logic [31:0] b_reg,
                                  input logic [3:0] fl, output logic [31:0] res,
                                  output logic [15:0] e, output bit upd, output logic [3:0] nfl);
        logic [63:0] ua, ub, w, t;
        longint sa, sb;
        bit fn, fz, fc, fv, pass, s_ok, wr, nc, nv;
        int sh;
        int op;
        ua = {32'd0, a};
        ub = f[10] ? {54'd0, f[9:0]} : {32'd0, b_reg};
        sa = longint'($signed(a));
        sb = f[10] ? longint'(ub) : longint'($signed(b_reg));
        {fn, fz, fc, fv} = fl;
        nc = fc; nv = fv; w = 64'd0; s_ok = 0; wr = 1; op = int'(f[27:24]);
        sh = int'(ub[4:0]);
        case (f[31:28])
            4'd0: pass = fz;            4'd1: pass = !fz;
            4'd2: pass = fc;            4'd3: pass = !fc;
            4'd4: pass = fn;            4'd5: pass = !fn;
            4'd6: pass = fv;            4'd7: pass = !fv;
            4'd8: pass = fc && !fz;     4'd9: pass = !fc || fz;
            4'd10: pass = (fn == fv);   4'd11: pass = (fn != fv);
            4'd12: pass = !fz && (fn == fv);
            4'd13: pass = fz || (fn != fv);
            default: pass = 1;
        endcase
        case (op)
            AND_: begin w = ua & ub; s_ok = 1; end
            EOR:  begin w = ua ^ ub; s_ok = 1; end
            ORR:  begin w = ua | ub; s_ok = 1; end
            MOV:  begin w = ub; s_ok = 1; end
            MVN:  begin w = ~ub; s_ok = 1; end
            SUB, CMP: begin
                w = ua - ub; nc = (ua >= ub); nv = ovf(sa - sb);
                s_ok = (op == SUB); wr = (op == SUB);
            end
            RSB: begin w = ub - ua; nc = (ub >= ua); nv = ovf(sb - sa); s_ok = 1; end
            ADD: begin w = ua + ub; nc = w[32]; nv = ovf(sa + sb); s_ok = 1; end
            ADC: begin w = ua + ub + 64'(fc); nc = w[32]; nv = ovf(sa + sb + longint'(fc)); s_ok = 1; end
            SBC: begin
                w = ua - ub - 64'(!fc); nc = (ua >= ub + 64'(!fc));
                nv = ovf(sa - sb - longint'(!fc)); s_ok = 1;
            end
            LDR: w = 64'd0;
`ifdef ALU_SHIFT_EN
            LSL: begin w = ua << sh; if (sh != 0) nc = w[32]; s_ok = 1; end
            LSR: begin w = ua >> sh; t = ua >> (sh - 1); if (sh != 0) nc = t[0]; s_ok = 1; end
`endif
            default: begin w = 64'd0; wr = 0; end
        endcase
        res = w[31:0];
        e   = (pass && wr) ? (16'd1 << f[22:19]) : 16'd0;
        upd = pass && ((f[23] && s_ok) || op == CMP);
        nfl = {res[31], res == 32'd0, nc, nv};
    endfunction

    always_comb model(fetch, s1, s2, m_fl, m_res, m_en, m_upd, m_nfl);

    always @(posedge clk or negedge reset) begin
        if (!reset) m_fl <= 4'd0;
        else if (m_upd) m_fl <= m_nfl;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("result", result, m_res);
            chk("en", {16'd0, en}, {16'd0, m_en});
            chk("addressbus", addressbus, sel ? abus : pc);
            chk("flags", {28'd0, n, z, c, v}, {28'd0, m_fl});
            if (lc_res)  chk("lit_result", result, l_res);
            if (lc_en)   chk("lit_en", {16'd0, en}, {16'd0, l_en});
            if (lc_addr) chk("lit_addr", addressbus, l_addr);
            if (lc_fl)   chk("lit_flags", {28'd0, n, z, c, v}, {28'd0, l_fl});
        end
    end

    function automatic logic [31:0] ins(input int cond, input int op, input int s, input int rd,
                                        input int imm_f, input int imm);
        return {4'(cond), 4'(op), 1'(s), 4'(rd), 4'd1, 4'd2, 1'(imm_f), 10'(imm)};
    endfunction

    task automatic step(input logic [31:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        fetch = f; s1 = a; s2 = b;
        lc_res = 0; lc_en = 0; lc_addr = 0; lc_fl = 0;
    endtask

    task automatic exp_res(input logic [31:0] x);  lc_res = 1;  l_res = x;  endtask
    task automatic exp_en(input logic [15:0] x);   lc_en = 1;   l_en = x;   endtask
    task automatic exp_addr(input logic [31:0] x); lc_addr = 1; l_addr = x; endtask
    task automatic exp_fl(input logic [3:0] x);    lc_fl = 1;   l_fl = x;   endtask

    logic [31:0] pa [4] = '{32'd5, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] pb [4] = '{32'd3, 32'd5, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] ca [4] = '{32'd3, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] cb [4] = '{32'd5, 32'd3, 32'd5, 32'd1};

    initial begin
        run = 1'b1;
        lc_fl = 1; l_fl = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        pc = 32'h10; abus = 32'h80;
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0);
        sel = 0; exp_addr(32'h10);
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0);
        sel = 1; exp_addr(32'h80);
        step(ins(AL, ADD, 0, 5, 0, 0), 2, 3);
        sel = 0; exp_res(5); exp_en(16'h0020);
        step(ins(AL, STR, 0, 5, 0, 0), 2, 3);  exp_en(16'h0000);
        step(ins(AL, CMP, 0, 5, 0, 0), 2, 3);  exp_en(16'h0000);
        step(ins(AL, NOP, 0, 5, 0, 0), 2, 3);  exp_en(16'h0000);

        step(ins(AL, ADD, 1, 1, 0, 0), 32'hFFFF_FFFF, 1); exp_res(0);
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0);            exp_fl(4'b0110);
        step(ins(AL, ADD, 1, 1, 0, 0), 32'h7FFF_FFFF, 1); exp_res(32'h8000_0000);
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0);            exp_fl(4'b1001);
        step(ins(AL, CMP, 0, 3, 0, 0), 3, 5); exp_en(0); exp_res(32'hFFFF_FFFE);
        step(ins(EQ, MOV, 0, 4, 0, 0), 0, 7); exp_en(0); exp_fl(4'b1000);

        step(ins(AL, SUB, 1, 2, 0, 0), 5, 3); exp_res(2);
        step(ins(AL, ADC, 0, 2, 0, 0), 10, 20); exp_fl(4'b0010); exp_res(31);
        step(ins(AL, SBC, 0, 2, 0, 0), 10, 3); exp_res(7);
        step(ins(AL, SUB, 1, 2, 0, 0), 3, 5);
        step(ins(AL, SBC, 0, 2, 0, 0), 10, 3); exp_res(6); exp_fl(4'b1000);
        step(ins(AL, ADD, 0, 7, 1, 10'h3FF), 1, 32'hDEAD); exp_res(32'h400); exp_en(16'h0080);

        step(ins(AL, LSL, 1, 2, 1, 1), 32'h8000_0001, 0);
`ifdef ALU_SHIFT_EN
        exp_res(32'h2); exp_en(16'h0004);
`else
        exp_res(0); exp_en(0);
`endif
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0);
`ifdef ALU_SHIFT_EN
        exp_fl(4'b0010);
`else
        exp_fl(4'b1000);
`endif
        step(ins(AL, LSR, 1, 3, 1, 0), 5, 0);
        step(ins(AL, LSR, 1, 3, 1, 4), 32'h18, 0);
        step(ins(AL, LSL, 1, 3, 0, 0), 32'h1234_5678, 32'd36);

        for (int k = 0; k < 4; k++) begin
            step(ins(AL, CMP, 0, 0, 0, 0), ca[k], cb[k]);
            for (int cd = 0; cd < 16; cd++)
                step(ins(cd, MOV, 0, cd, 0, 0), 0, 32'h55);
        end
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 4; k++) begin
                step(ins(AL, op, 1, op, 0, 0), pa[k], pb[k]);
                step(ins(AL, op, 1, 15 - op, 1, k * 37), pa[k], 32'hFFFF);
            end
        end

        step(ins(AL, ADD, 1, 1, 0, 0), 32'h7FFF_FFFF, 1);
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0); exp_fl(4'b1001);
        step(ins(AL, ADD, 1, 1, 0, 0), 32'hFFFF_FFFF, 1);
        reset = 1'b0; exp_fl(4'b0000);
        step(ins(AL, ADD, 1, 1, 0, 0), 32'hFFFF_FFFF, 1); exp_fl(4'b0000);
        step(ins(AL, ADD, 1, 1, 0, 0), 32'hFFFF_FFFF, 1);
        reset = 1'b1; exp_fl(4'b0000);
        step(ins(AL, NOP, 0, 0, 0, 0), 0, 0); exp_fl(4'b0110);

        @(posedge clk);
        #1 run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
